// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants, axis phase and coordinate types
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Coordinates are 10 bits wide, so no axis may exceed this many positions.
   localparam int COORD_RANGE  = 1024;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   typedef logic [9:0] coord_t;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
// count is registered; count_next/phase_next let the top register its decodes with zero latency.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
   output logic [9:0] count,
   output logic [9:0] count_next,
   output logic [1:0] phase_next,
   output logic       wrap
);

   localparam int     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam coord_t LAST       = coord_t'(TOTAL - 1);
   localparam coord_t END_ACTIVE = coord_t'(ACTIVE - 1);
   localparam coord_t END_FRONT  = coord_t'(ACTIVE + FP - 1);
   localparam coord_t END_SYNC   = coord_t'(ACTIVE + FP + SYNC - 1);

   if (TOTAL > COORD_RANGE) begin : g_total_too_large
      $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_RANGE);
   end

   if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_empty_phase
      $error("vga_axis_counter: every phase needs at least one position");
   end

   phase_t state;
   phase_t state_next;
   coord_t count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         state   <= PH_ACTIVE;
      end else begin
         count_q <= count_next;
         state   <= state_next;
      end
   end

   always_comb begin
      count_next = count_q;
      if (advance) begin
         count_next = (count_q == LAST) ? '0 : count_q + 10'd1;
      end
   end

   // The phase moves only when the counter steps off the last position of a phase.
   always_comb begin
      state_next = state;
      if (advance) begin
         case (state)
            PH_ACTIVE: if (count_q == END_ACTIVE) state_next = PH_FRONT;
            PH_FRONT:  if (count_q == END_FRONT)  state_next = PH_SYNC;
            PH_SYNC:   if (count_q == END_SYNC)   state_next = PH_BACK;
            PH_BACK:   if (count_q == LAST)       state_next = PH_ACTIVE;
            default:   state_next = PH_ACTIVE;
         endcase
      end
   end

   assign count      = count_q;
   assign phase_next = state_next;
   assign wrap       = advance && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster generator: x/y, syncs, display_on, line/frame pulses, frame counter
// Optional macro VGA_TIMING_PIXEL_CE_EN adds pix_ce so the raster advances only on enabled clocks.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef VGA_TIMING_PIXEL_CE_EN
   input  logic       pix_ce,
`endif
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_end,
   output logic       frame_end,
   output logic [7:0] frame_count
);

   localparam coord_t H_LAST = coord_t'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam coord_t V_LAST = coord_t'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);

   logic       tick;
   coord_t     h_count_next;
   coord_t     v_count_next;
   logic [1:0] h_phase_next;
   logic [1:0] v_phase_next;
   logic       h_wrap;
   logic       v_wrap;

   logic       hsync_q;
   logic       vsync_q;
   logic       display_q;
   logic       line_end_q;
   logic       frame_end_q;
   logic [7:0] frame_count_q;

`ifdef VGA_TIMING_PIXEL_CE_EN
   assign tick = pix_ce;
`else
   assign tick = 1'b1;
`endif

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (tick),
      .count      (x),
      .count_next (h_count_next),
      .phase_next (h_phase_next),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (h_wrap),
      .count      (y),
      .count_next (v_count_next),
      .phase_next (v_phase_next),
      .wrap       (v_wrap)
   );

   // Decodes use the next counter/phase values so each registered output lines up with x/y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         display_q     <= 1'b1;
         line_end_q    <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         hsync_q       <= (h_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_q       <= (v_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         display_q     <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
         line_end_q    <= (h_count_next == H_LAST);
         frame_end_q   <= (h_count_next == H_LAST) && (v_count_next == V_LAST);
         if (v_wrap) begin
            frame_count_q <= frame_count_q + 8'd1;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_q;
   assign frame_count = frame_count_q;

`ifdef VGA_TIMING_PIXEL_CE_EN
   // A pixel spans several clocks; the pulses mark only the enabled clock that ends it.
   assign line_end  = line_end_q & pix_ce;
   assign frame_end = frame_end_q & pix_ce;
`else
   assign line_end  = line_end_q;
   assign frame_end = frame_end_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset bench for vga_timing_gen against a tick-count raster model
module tb_vga_timing_gen;

   localparam int B_HA = 8;
   localparam int B_HF = 2;
   localparam int B_HS = 3;
   localparam int B_HB = 2;
   localparam int B_VA = 5;
   localparam int B_VF = 1;
   localparam int B_VS = 2;
   localparam int B_VB = 2;

`ifdef VGA_TIMING_PIXEL_CE_EN
   localparam int N_CYCLES = 60000;
`else
   localparam int N_CYCLES = 44000;
`endif
   localparam int B_RESET_WINDOW = 3000;

   logic       clk = 1'b0;
   logic       rst_n_a;
   logic       rst_n_b;
   logic       pix_ce;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_hsync, a_vsync, a_de, a_le, a_fe;
   logic       b_hsync, b_vsync, b_de, b_le, b_fe;
   logic [7:0] a_fc, b_fc;

   int cmp_count = 0;
   int err_count = 0;

   longint ta;
   longint tb;
   int     hold_a;
   int     hold_b;

   always #5 clk = ~clk;

   vga_timing_gen dut_a (
      .clk         (clk),
      .rst_n       (rst_n_a),
`ifdef VGA_TIMING_PIXEL_CE_EN
      .pix_ce      (pix_ce),
`endif
      .x           (a_x),
      .y           (a_y),
      .hsync       (a_hsync),
      .vsync       (a_vsync),
      .display_on  (a_de),
      .line_end    (a_le),
      .frame_end   (a_fe),
      .frame_count (a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
      .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
      .SYNC_POL (1'b1)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n_b),
`ifdef VGA_TIMING_PIXEL_CE_EN
      .pix_ce      (pix_ce),
`endif
      .x           (b_x),
      .y           (b_y),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .display_on  (b_de),
      .line_end    (b_le),
      .frame_end   (b_fe),
      .frame_count (b_fc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_count++;
      if (obs !== exp) begin
         err_count++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected raster after t pixel advances since reset, derived purely from the timing arithmetic.
   task automatic check_all(input string p, input longint t,
                            input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input logic pol, input logic ce,
                            input logic [9:0] ox, input logic [9:0] oy,
                            input logic ohs, input logic ovs, input logic ode,
                            input logic ole, input logic ofe, input logic [7:0] ofc);
      int     ht, vt, ex, ey, efc;
      longint line;
      logic   hact, vact, ehs, evs, ede, ele, efe;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      ex   = int'(t % ht);
      line = t / ht;
      ey   = int'(line % vt);
      efc  = int'((t / (ht * vt)) % 256);
      hact = (ex >= ha + hf) && (ex < ha + hf + hs);
      vact = (ey >= va + vf) && (ey < va + vf + vs);
      ehs  = hact ? pol : ~pol;
      evs  = vact ? pol : ~pol;
      ede  = (ex < ha) && (ey < va);
      ele  = (ex == ht - 1) && ce;
      efe  = (ex == ht - 1) && (ey == vt - 1) && ce;
      check({p, "x"},           32'(ox),  32'(ex));
      check({p, "y"},           32'(oy),  32'(ey));
      check({p, "hsync"},       32'(ohs), 32'(ehs));
      check({p, "vsync"},       32'(ovs), 32'(evs));
      check({p, "display_on"},  32'(ode), 32'(ede));
      check({p, "line_end"},    32'(ole), 32'(ele));
      check({p, "frame_end"},   32'(ofe), 32'(efe));
      check({p, "frame_count"}, 32'(ofc), 32'(efc));
   endtask

   task automatic check_a(input string p);
      check_all(p, ta, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, pix_ce,
                a_x, a_y, a_hsync, a_vsync, a_de, a_le, a_fe, a_fc);
   endtask

   task automatic check_b(input string p);
      check_all(p, tb, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, pix_ce,
                b_x, b_y, b_hsync, b_vsync, b_de, b_le, b_fe, b_fc);
   endtask

   initial begin
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      pix_ce  = 1'b1;
      ta      = 0;
      tb      = 0;
      hold_a  = 2;
      hold_b  = 2;

      for (int c = 0; c < N_CYCLES; c++) begin
         @(posedge clk);
         if (!rst_n_a) ta = 0;
         else if (pix_ce) ta++;
         if (!rst_n_b) tb = 0;
         else if (pix_ce) tb++;

         #1;
`ifdef VGA_TIMING_PIXEL_CE_EN
         pix_ce = ($urandom_range(0, 3) != 0);
`endif
         #1;
         check_a("a.");
         check_b("b.");

         @(negedge clk);
         if (!rst_n_a) begin
            if (hold_a == 0) rst_n_a = 1'b1;
            else hold_a--;
         end else if ($urandom_range(0, 2999) == 0) begin
            rst_n_a = 1'b0;
            hold_a  = $urandom_range(0, 3);
            ta      = 0;
            #1;
            check_a("a.rst_now.");
         end

         if (!rst_n_b) begin
            if (hold_b == 0) rst_n_b = 1'b1;
            else hold_b--;
         end else if (c < B_RESET_WINDOW && $urandom_range(0, 499) == 0) begin
            rst_n_b = 1'b0;
            hold_b  = $urandom_range(0, 3);
            tb      = 0;
            #1;
            check_b("b.rst_now.");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
